dmem_arbiter: RTL and testbench

//   Shares the single-port DataRam between the pipeline MEM stage (cpu) and a debug/loader

---
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// DataRam arbiter: MEM-stage CPU port with fixed priority, debug port with starvation slot.
// Optional DMEM_ARB_STATS_EN adds saturating stall/grant counters.
module dmem_arbiter #(
  parameter int AW         = 6,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_spo,
  output logic          owner
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   dbg_cnt
`endif
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       dbg_win;
  logic       dbg_lose;

  // Reset term keeps the dbg port off the RAM while reset is held.
  assign dbg_win = reset & (state == IDLE) & dbg_req &
                   (~cpu_req | (starve_cnt == SMAX));
  assign dbg_lose = (state == IDLE) & dbg_req & ~dbg_win;

  assign cpu_rdata = ram_spo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (dbg_win) begin
        starve_cnt <= '0;
        dbg_rdata  <= ram_spo;
      end else if (dbg_lose && starve_cnt != SMAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner     = 1'b0;
    ram_a     = cpu_addr;
    ram_d     = cpu_wdata;
    ram_we    = reset & cpu_req & cpu_we;
    cpu_stall = 1'b0;
    dbg_ack   = (state == ACK);
    unique case (1'b1)
      dbg_win: begin
        owner     = 1'b1;
        ram_a     = dbg_addr;
        ram_d     = dbg_wdata;
        ram_we    = dbg_we;
        cpu_stall = cpu_req;
        state_nxt = ACK;
      end
      (state == ACK): state_nxt = IDLE;
      default: ;
    endcase
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      dbg_cnt   <= '0;
    end else begin
      if (cpu_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (dbg_win && dbg_cnt != 16'hFFFF)
        dbg_cnt <= dbg_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port DataRam.
// Define DMEM_ARB_STATS_EN to also exercise the statistics counters.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic [5:0]  ram_a;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_spo;
  logic        owner;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt, dbg_cnt;
`endif

  logic [31:0] mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_we) mem[ram_a] <= ram_d;

  assign ram_spo = mem[ram_a];

  dmem_arbiter #(.AW(6), .DW(32), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_we    (ram_we),
    .ram_spo   (ram_spo),
    .owner     (owner)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .dbg_cnt   (dbg_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    dbg_addr  = '0;
    dbg_wdata = '0;
    tick;
    tick;

    // reset state, with both ports requesting writes
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    #1;
    chk("rst_ack", dbg_ack, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_owner", owner, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_we", ram_we, 0);
    cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    reset = 1'b1;
    tick;

    // continuous cpu loads, no dbg traffic
    cpu_req = 1'b1;
    for (int a = 0; a < 64; a++) begin
      cpu_addr = 6'(a);
      #1;
      chk("ld_stall", cpu_stall, 0);
      chk("ld_addr", ram_a, 32'(a));
      chk("ld_rdata", cpu_rdata, 32'hA500_0000 | a);
      tick;
    end
    cpu_req = 1'b0;

    // dbg write then read, cpu idle
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd5;
    dbg_wdata = 32'hDEAD_BEEF;
    #1;
    chk("dw_owner", owner, 1);
    chk("dw_we", ram_we, 1);
    chk("dw_addr", ram_a, 5);
    chk("dw_data", ram_d, 32'hDEAD_BEEF);
    tick;
    chk("dw_ack", dbg_ack, 1);
    dbg_req = 1'b0;
    #1;
    chk("dw_ack_owner", owner, 0);
    tick;
    chk("dw_ack_drop", dbg_ack, 0);
    dbg_req = 1'b1; dbg_we = 1'b0;
    #1;
    chk("dr_owner", owner, 1);
    chk("dr_we", ram_we, 0);
    tick;
    chk("dr_ack", dbg_ack, 1);
    chk("dr_rdata", dbg_rdata, 32'hDEAD_BEEF);
    dbg_req = 1'b0;
    tick;

    // starvation pattern, counters start from reset
    reset = 1'b0;
    tick;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd2;
    for (int k = 0; k < 30; k++) begin
      #1;
      chk("st_owner", owner, ((k % 6) == 4) ? 1 : 0);
      chk("st_stall", cpu_stall, ((k % 6) == 4) ? 1 : 0);
      chk("st_ack", dbg_ack, ((k % 6) == 5) ? 1 : 0);
      if ((k % 6) == 5) chk("st_rdata", dbg_rdata, 32'hA500_0002);
      tick;
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stall", stall_cnt, 5);
    chk("stat_dbg", dbg_cnt, 5);
`endif

    // colliding stores to addr 9: forced dbg write, then cpu replay
    cpu_we = 1'b1; cpu_addr = 6'd9; cpu_wdata = 32'h1;
    dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'h2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cl_cpu_owner", owner, 0);
      chk("cl_cpu_data", ram_d, 32'h1);
      tick;
    end
    #1;
    chk("cl_dbg_owner", owner, 1);
    chk("cl_dbg_stall", cpu_stall, 1);
    chk("cl_dbg_data", ram_d, 32'h2);
    chk("cl_dbg_we", ram_we, 1);
    tick;
    chk("cl_mem_dbg", mem[9], 32'h2);
    chk("cl_ack", dbg_ack, 1);
    dbg_req = 1'b0;
    #1;
    chk("cl_replay_owner", owner, 0);
    chk("cl_replay_stall", cpu_stall, 0);
    chk("cl_replay_data", ram_d, 32'h1);
    tick;
    chk("cl_mem_final", mem[9], 32'h1);
    cpu_req = 1'b0; cpu_we = 1'b0;

    // reset asserted while in ACK
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd3;
    tick;
    chk("ra_ack", dbg_ack, 1);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    chk("ra_owner", owner, 0);
    chk("ra_stall", cpu_stall, 0);
    chk("ra_we", ram_we, 0);
    tick;
    chk("ra_ack_drop", dbg_ack, 0);
    chk("ra_starve", dut.starve_cnt, 0);
    chk("ra_owner2", owner, 0);
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0;
    tick;
    chk("ra_no_pulse", dbg_ack, 0);
    tick;
    chk("ra_no_pulse2", dbg_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
